// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a fast path for the RISC-V divide corner cases.
module ex_muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              result_valid_q, result_valid_d;

    logic              is_div, a_signed, b_signed, sa, sb, neg_start;
    logic              div_by_zero, overflow, fast_path;
    logic [XLEN-1:0]   a_mag, b_mag, fast_result;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_mul, acc_div, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_result;

    // Operand decode for the instruction currently presented by EX.
    always_comb begin
        is_div      = funct3[2];
        a_signed    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        b_signed    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        sa          = a_signed && op_a[XLEN-1];
        sb          = b_signed && op_b[XLEN-1];
        a_mag       = sa ? -op_a : op_a;
        b_mag       = sb ? -op_b : op_b;
        // REM takes the dividend's sign; every other signed op takes the product of signs.
        neg_start   = (funct3 == 3'd6) ? sa : (sa ^ sb);
        div_by_zero = is_div && (op_b == '0);
        overflow    = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        fast_path   = div_by_zero || overflow;
        if (div_by_zero) begin
            fast_result = funct3[1] ? op_a : '1;
        end else begin
            fast_result = funct3[1] ? '0 : op_a;
        end
    end

    // One iteration step and the final sign correction.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        acc_mul   = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_q};
        if (!div_diff[XLEN]) begin
            acc_div = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_div = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (funct3_q)
            3'd0:                fin_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fin_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fin_result = quo_fix;
            default:             fin_result = rem_fix;
        endcase
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        funct3_d       = funct3_q;
        neg_d          = neg_q;
        m_d            = m_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    funct3_d = funct3;
                    neg_d    = neg_start;
                    cnt_d    = CW'(XLEN-1);
                    if (fast_path) begin
                        result_d       = fast_result;
                        result_valid_d = 1'b1;
                        state_d        = DONE;
                    end else begin
                        m_d     = is_div ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = funct3_q[2] ? acc_div : acc_mul;
                if (cnt_q == '0) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIN: begin
                result_d       = fin_result;
                result_valid_d = 1'b1;
                state_d        = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A redirect kills the op outright and leaves the last result untouched.
        if (flush) begin
            state_d        = IDLE;
            result_d       = result_q;
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            funct3_q       <= '0;
            neg_q          <= 1'b0;
            m_q            <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            funct3_q       <= funct3_d;
            neg_q          <= neg_d;
            m_q            <= m_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign stall        = (start && (state_q == IDLE)) || (state_q == RUN) || (state_q == FIN);
    assign busy         = (state_q == RUN) || (state_q == FIN);
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: table of directed M-ext ops plus
// hand-written back-to-back, flush and async-reset sequences.
module tb_ex_muldiv_sequencer;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int total;
    int passed;
    vec_t vecs[$];

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input bit fast);
        vec_t v;
        v.name = name;
        v.f    = f;
        v.a    = a;
        v.b    = b;
        v.exp  = exp;
        v.fast = fast;
        return v;
    endfunction

    // Presents one op, holds start until the result pulse, then drops it.
    task automatic run_vec(input vec_t v);
        int cycles;
        int stalls;
        bit got;
        @(negedge clk);
        start  = 1'b1;
        funct3 = v.f;
        op_a   = v.a;
        op_b   = v.b;
        #1;
        stalls = stall ? 1 : 0;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (result_valid) got = 1'b1;
            else if (stall) stalls++;
        end
        check({v.name, " latency"}, 32'(cycles), v.fast ? 32'd1 : 32'd34);
        check({v.name, " stall cycles"}, 32'(stalls), v.fast ? 32'd1 : 32'd34);
        check({v.name, " result"}, result, v.exp);
        check({v.name, " stall in done"}, {31'd0, stall}, 32'd0);
        check({v.name, " busy in done"}, {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({v.name, " valid one cycle"}, {31'd0, result_valid}, 32'd0);
        check({v.name, " result held"}, result, v.exp);
    endtask

    initial begin
        int pulses;
        int first_at;
        int gap;
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;

        vecs.push_back(mk("MUL 7*-3",        3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0));
        vecs.push_back(mk("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0));
        vecs.push_back(mk("MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0));
        vecs.push_back(mk("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mk("MULH -1*-1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("MULH -1*1",       3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mk("MUL 2^16*2^16",   3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("MULHU 2^16*2^16", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0));
        vecs.push_back(mk("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0));
        vecs.push_back(mk("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mk("DIV 7/-2",        3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0));
        vecs.push_back(mk("REM 7/-2",        3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
        vecs.push_back(mk("DIVU 100/7",      3'd5, 32'd100,       32'd7,         32'd14,        1'b0));
        vecs.push_back(mk("REMU 100/7",      3'd7, 32'd100,       32'd7,         32'd2,         1'b0));
        vecs.push_back(mk("DIV min/1",       3'd4, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0));
        vecs.push_back(mk("DIVU x/0",        3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1));
        vecs.push_back(mk("REMU x/0",        3'd7, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1));
        vecs.push_back(mk("DIV 0/0",         3'd4, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1));
        vecs.push_back(mk("DIV min/-1",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1));
        vecs.push_back(mk("REM min/-1",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1));

        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset valid", {31'd0, result_valid}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Two DIVU ops with start held through DONE: the second must start only from IDLE.
        @(negedge clk);
        start    = 1'b1;
        funct3   = 3'd5;
        op_a     = 32'd100;
        op_b     = 32'd7;
        pulses   = 0;
        first_at = 0;
        gap      = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (result_valid) begin
                pulses++;
                if (pulses == 1) begin
                    check("b2b first result", result, 32'd14);
                    first_at = c;
                    op_b     = 32'd10;
                end else if (pulses == 2) begin
                    check("b2b second result", result, 32'd10);
                    gap   = c - first_at;
                    start = 1'b0;
                end
            end
        end
        check("b2b pulse count", 32'(pulses), 32'd2);
        check("b2b pulse spacing", 32'(gap), 32'd35);

        // Flush in the middle of RUN.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush valid", {31'd0, result_valid}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check("flush no pulse", 32'(pulses), 32'd0);
        check("flush result kept", result, 32'd10);

        // Flush in IDLE beats start, even for a fast-path op.
        @(negedge clk);
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'd5;
        op_a   = 32'd5;
        op_b   = 32'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("idle flush busy", {31'd0, busy}, 32'd0);
        check("idle flush valid", {31'd0, result_valid}, 32'd0);
        check("idle flush result", result, 32'd10);
        @(posedge clk);
        @(negedge clk);
        check("idle flush no late valid", {31'd0, result_valid}, 32'd0);

        // Asynchronous reset between edges in RUN.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd0;
        op_a   = 32'd3;
        op_b   = 32'd5;
        repeat (5) @(posedge clk);
        #2;
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        start = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset stall", {31'd0, stall}, 32'd0);
        check("async reset valid", {31'd0, result_valid}, 32'd0);
        check("async reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
